uart_prog_loader: RTL
=====================

# uart_prog_loader

Boot-time program loader that sits directly downstream of `uart_rx` in `rv32i_top_Soc`. While program mode is requested (`progEnB` low), it consumes received bytes, packs them little-endian into 32-bit words and writes them sequentially into instruction memory from word 0. It holds the core in reset during loading. When program mode ends, it flushes any partial word and releases the core. It also forwards each accepted byte to an echo transmitter (`rx_echo` path).

## Interface
- `ADDR_WIDTH`, 13: instruction-memory word-address width (8192 words = 32 KiB).
- `ECHO_EN`, 1: 1 forwards accepted bytes on the echo port; 0 ties `echoEn` low and ignores `echoBusy`.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `progEnB` in 1: program-mode request, active low, asynchronous pin; synchronised internally.
- `rxDataEn` in 1: one-cycle strobe; `rxData` is valid.
- `rxData` in 8: received byte.
- `FfFull` out 1: back-pressure to `uart_rx`; 1 = byte not accepted this cycle.
- `memWe` out 1: instruction-memory write strobe, one cycle per word.
- `memAddr` out ADDR_WIDTH: word address.
- `memWdata` out 32: write data; byte 0 received goes to [7:0].
- `memBe` out 4: byte-lane enables.
- `echoEn` out 1: one-cycle strobe to the echo UART transmitter.
- `echoData` out 8: byte to echo.
- `echoBusy` in 1: echo transmitter cannot take a byte.
- `coreRst` out 1: active-high reset to the RV32I core.
- `loadDone` out 1: high in RUN.
- `overflow` out 1: sticky; a byte arrived beyond the last word address.
- `wordCount` out ADDR_WIDTH+1: number of words written in the current load, including a flushed partial word.

## Operation
- **Synchroniser:** 2-flop synchroniser on `progEnB` produces `prog` = !synced value. `prog` reacts 2 cycles after a pin change.
- **FSM states:** LOAD, FLUSH, RUN.
- **Reset:** state=LOAD, byteIdx=0, addr=0, wordCount=0, shift register=0, overflow=0. Outputs after reset: coreRst=1, memWe=0, memBe=0, memAddr=0, memWdata=0, echoEn=0, echoData=0, FfFull=0, loadDone=0. Synchroniser flops reset to 1 (not in program mode).
- **LOAD:**
  - A byte is accepted when `rxDataEn && !FfFull`.
  - `FfFull = ECHO_EN && echoBusy` in LOAD; 0 otherwise.
  - An accepted byte is placed in lane byteIdx, and byteIdx increments mod 4.
  - When byteIdx==3 and a byte is accepted: the next cycle asserts memWe with memAddr=addr, memBe=4'b1111 and the full word. Then addr increments and wordCount increments.
  - Lane storage clears after each word write.
  - With ECHO_EN=1, every accepted byte gives echoEn=1 and echoData=byte the next cycle.
  - `rxDataEn` while FfFull=1 is dropped; uart_rx is responsible for holding the byte.
- **Overflow:** if addr==2^ADDR_WIDTH-1 has already been written, further accepted bytes are discarded (still echoed), overflow=1, and memWe stays low.
- **LOAD→FLUSH:** when `prog`=0.
  - If a byte is accepted in the same cycle, it is stored first, and the transition happens that cycle.
- **FLUSH (1 cycle):**
  - If byteIdx≠0 and not overflowed: memWe=1, memBe has lanes [byteIdx-1:0] set, unused lanes of memWdata are 0, and wordCount increments.
  - Otherwise no write.
  - Next state is RUN.
- **RUN:** coreRst=0, loadDone=1, bytes ignored, FfFull=0.
- **RUN→LOAD:** when `prog`=1. Entering LOAD sets coreRst=1 and clears addr, byteIdx, wordCount and overflow in that cycle.
- **Reset mid-load:** discards the partial word; no flush write.

## Timing
- Byte strobe (cycle N) to echoEn: N+1.
- 4th byte of a word (cycle N) to memWe: N+1. Writes never coincide because byte strobes are ≥1 UART bit apart; back-to-back strobes on consecutive cycles must still be handled (1 byte/cycle throughput).
- `progEnB` rise (cycle N) → FLUSH at N+2 → coreRst falls and loadDone rises at N+3.
- `progEnB` fall (cycle N) → coreRst=1 at N+3.
- All outputs are registered; no combinational path from input to output except FfFull ← echoBusy.

## Test plan
- **Reset:** hold rst 3 cycles with progEnB=0 → all outputs at reset values, coreRst=1, FfFull=0.
- **Full program load:** 348 bytes 0x00..0x5B repeating, 868-cycle bit spacing, then progEnB=1 → 87 writes at addr 0..86. Word 0 = 0x03020100, each write with memBe=F, no flush write, wordCount=87. coreRst falls 3 cycles after progEnB rises; 348 echo strobes in order.
- **Partial flush:** 6 bytes 11 22 33 44 55 66, then progEnB=1 → write addr 0 0x44332211 BE=F, then FLUSH write addr 1 0x00006655 BE=3, wordCount=2.
- **Back-pressure:** echoBusy=1 during rxDataEn → FfFull=1, byte not stored, no echo. After echoBusy drops, a retried byte is accepted normally.
- **Overflow:** ADDR_WIDTH=2, 20 bytes → 4 writes (addr 0..3), overflow=1, no 5th write, remaining bytes echoed. Re-entering LOAD clears overflow.
- **Reload:** RUN, then progEnB=0 → coreRst=1 after 3 cycles, addr restarts at 0. A new 4-byte word writes addr 0. rst asserted after 2 bytes → no write, state LOAD.

Source files
------------

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - boot-time UART program loader
// Packs received bytes little-endian into instruction-memory words and holds the core in reset while loading.
module uart_prog_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter bit ECHO_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  progEnB,
  input  logic                  rxDataEn,
  input  logic [7:0]            rxData,
  output logic                  FfFull,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memWdata,
  output logic [3:0]            memBe,
  output logic                  echoEn,
  output logic [7:0]            echoData,
  input  logic                  echoBusy,
  output logic                  coreRst,
  output logic                  loadDone,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   wordCount
);

  typedef enum logic [1:0] {LOAD, FLUSH, RUN} state_t;

  state_t                state_q, state_d;
  logic [1:0]            sync_q;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [31:0]           lanes_q, lanes_d;
  logic [ADDR_WIDTH:0]   wcount_q, wcount_d;
  logic                  ovf_q, ovf_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  echo_en_q, echo_en_d;
  logic [7:0]            echo_data_q, echo_data_d;
  logic                  core_rst_q, core_rst_d;
  logic                  done_q, done_d;

  logic prog;
  logic full;
  logic ff_full;
  logic accept;

  assign prog    = ~sync_q[1];
  // The word count reaching 2^ADDR_WIDTH means the last address has been written.
  assign full    = wcount_q[ADDR_WIDTH];
  assign ff_full = (state_q == LOAD) && ECHO_EN && echoBusy;
  assign accept  = (state_q == LOAD) && rxDataEn && !ff_full;

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    lanes_d     = lanes_q;
    wcount_d    = wcount_q;
    ovf_d       = ovf_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = 4'b0000;
    echo_en_d   = 1'b0;
    echo_data_d = echo_data_q;
    // Core reset and done follow the state with one cycle of lag in both directions.
    core_rst_d  = (state_q == LOAD);
    done_d      = (state_q != LOAD);

    case (state_q)
      LOAD: begin
        if (accept) begin
          if (ECHO_EN) begin
            echo_en_d   = 1'b1;
            echo_data_d = rxData;
          end
          if (full) begin
            ovf_d = 1'b1;
          end else if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            be_d       = 4'b1111;
            addr_d     = wcount_q[ADDR_WIDTH-1:0];
            wdata_d    = {rxData, lanes_q[23:0]};
            lanes_d    = '0;
            byte_idx_d = 2'd0;
            wcount_d   = wcount_q + 1'b1;
          end else begin
            lanes_d[{byte_idx_q, 3'b000} +: 8] = rxData;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
        if (!prog) state_d = FLUSH;
      end
      FLUSH: begin
        if (byte_idx_q != 2'd0 && !ovf_q) begin
          we_d     = 1'b1;
          be_d     = {1'b0, byte_idx_q == 2'd3, byte_idx_q >= 2'd2, 1'b1};
          addr_d   = wcount_q[ADDR_WIDTH-1:0];
          wdata_d  = lanes_q;
          wcount_d = wcount_q + 1'b1;
        end
        lanes_d    = '0;
        byte_idx_d = 2'd0;
        state_d    = RUN;
      end
      RUN: begin
        if (prog) begin
          state_d    = LOAD;
          wcount_d   = '0;
          ovf_d      = 1'b0;
          byte_idx_d = 2'd0;
          lanes_d    = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      sync_q      <= 2'b11;
      byte_idx_q  <= 2'd0;
      lanes_q     <= '0;
      wcount_q    <= '0;
      ovf_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= 4'b0000;
      echo_en_q   <= 1'b0;
      echo_data_q <= 8'h00;
      core_rst_q  <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[0], progEnB};
      byte_idx_q  <= byte_idx_d;
      lanes_q     <= lanes_d;
      wcount_q    <= wcount_d;
      ovf_q       <= ovf_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      echo_en_q   <= echo_en_d;
      echo_data_q <= echo_data_d;
      core_rst_q  <= core_rst_d;
      done_q      <= done_d;
    end
  end

  assign FfFull    = ff_full;
  assign memWe     = we_q;
  assign memAddr   = addr_q;
  assign memWdata  = wdata_q;
  assign memBe     = be_q;
  assign echoEn    = echo_en_q;
  assign echoData  = echo_data_q;
  assign coreRst   = core_rst_q;
  assign loadDone  = done_q;
  assign overflow  = ovf_q;
  assign wordCount = wcount_q;

endmodule
